// File: rtl/chiptune_pkg.sv
// Shared definitions for the chiptune mixer: modulator mode encodings and
// small width/saturation helpers.
package chiptune_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    // Width of an index over n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp an unsigned value to the largest number representable in width bits.
    function automatic logic [31:0] sat_u(input logic [31:0] value, input int width);
        logic [31:0] lim;
        lim = (32'd1 << width) - 32'd1;
        return (value > lim) ? lim : value;
    endfunction

endpackage

// File: rtl/chiptune_pwm_mod.sv
// 1-bit audio modulator: PWM with period-aligned duty update, or first-order
// sigma-delta; both restart cleanly whenever the mode input changes.
module chiptune_pwm_mod
    import chiptune_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mode,
    input  logic [OUT_W-1:0] i_dac,
    output logic             o_pwm
);

    logic             r_mode;
    logic [OUT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_duty;
    logic [OUT_W:0]   r_acc;
    logic             r_pwm;
    logic             w_mode_chg;
    logic [OUT_W:0]   w_acc_nxt;

    assign w_mode_chg = (i_mode != r_mode);
    assign w_acc_nxt  = {1'b0, r_acc[OUT_W-1:0]} + {1'b0, i_dac};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= MODE_PWM;
            r_cnt  <= '0;
            r_duty <= '0;
            r_acc  <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_mode <= i_mode;
            if (w_mode_chg) begin
                r_cnt  <= '0;
                r_duty <= '0;
                r_acc  <= '0;
                r_pwm  <= 1'b0;
            end else if (r_mode == MODE_PWM) begin
                r_cnt <= r_cnt + 1'b1;
                // Duty only changes on the last count so a period is never split.
                if (&r_cnt)
                    r_duty <= i_dac;
                r_pwm <= (r_cnt < r_duty);
            end else begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    // Forced low during the cycle the mode flips so the old mode never leaks out.
    always_comb begin
        o_pwm = 1'b0;
        if (!w_mode_chg)
            o_pwm = (r_mode == MODE_SD) ? r_acc[OUT_W] : r_pwm;
    end

endmodule

// File: rtl/chiptune_mixer_pwm.sv
// N-voice mixer: per-channel volume/mute, sum, master gain with saturation,
// sticky clip flag, and a 1-bit PWM / sigma-delta audio output.
module chiptune_mixer_pwm
    import chiptune_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 4,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_sample_in,
    input  logic [NUM_CH*VOL_W-1:0]      i_volume,
    input  logic [NUM_CH-1:0]            i_mute,
    input  logic [1:0]                   i_gain,
    input  logic                         i_mode,
    input  logic                         i_clip_clr,
    output logic [OUT_W-1:0]             o_dac,
    output logic                         o_dac_valid,
    output logic                         o_pwm,
    output logic                         o_clip
);

    localparam int P      = SAMPLE_W + VOL_W;
    localparam int S      = P + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0);
    localparam int M_W    = S + 3;
    localparam int STAGES = 3;

    logic [NUM_CH-1:0][P-1:0] w_prod;
    logic [NUM_CH-1:0][P-1:0] r_prod;
    logic [STAGES:1]          r_vld_pipe;
    logic [1:0]               r_gain1;
    logic [1:0]               r_gain2;
    logic [S-1:0]             w_sum;
    logic [S-1:0]             r_sum;
    logic [M_W-1:0]           w_m;
    logic [OUT_W-1:0]         w_sat;
    logic                     w_ovf;
    logic [OUT_W-1:0]         r_dac;
    logic                     r_clip;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic [SAMPLE_W-1:0] w_s;
        logic [VOL_W-1:0]    w_v;
        assign w_s       = i_sample_in[g*SAMPLE_W +: SAMPLE_W];
        assign w_v       = i_volume[g*VOL_W +: VOL_W];
        assign w_prod[g] = i_mute[g] ? '0 : P'(w_s) * P'(w_v);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_sum = w_sum + S'(r_prod[i]);
    end

    // Gain shift first, then drop to the DAC resolution; the 3 spare bits catch overflow.
    assign w_m   = (M_W'(r_sum) << r_gain2) >> (S - OUT_W);
    assign w_sat = OUT_W'(sat_u(32'(w_m), OUT_W));
    assign w_ovf = (w_m > M_W'((1 << OUT_W) - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_prod     <= '0;
            r_gain1    <= '0;
            r_gain2    <= '0;
            r_sum      <= '0;
            r_dac      <= '0;
            r_clip     <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_sample_valid};
            if (i_sample_valid) begin
                r_prod  <= w_prod;
                r_gain1 <= i_gain;
            end
            if (r_vld_pipe[1]) begin
                r_sum   <= w_sum;
                r_gain2 <= r_gain1;
            end
            if (r_vld_pipe[2])
                r_dac <= w_sat;
            if (r_vld_pipe[2] && w_ovf)
                r_clip <= 1'b1;
            else if (i_clip_clr)
                r_clip <= 1'b0;
        end
    end

    assign o_dac       = r_dac;
    assign o_dac_valid = r_vld_pipe[STAGES];
    assign o_clip      = r_clip;

    chiptune_pwm_mod #(
        .OUT_W (OUT_W)
    ) u_mod (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_mode (i_mode),
        .i_dac  (r_dac),
        .o_pwm  (o_pwm)
    );

endmodule

// File: tb/tb_chiptune_mixer_pwm.sv
// Directed bench for chiptune_mixer_pwm at default parameters (P=8, S=10, >>2).
module tb_chiptune_mixer_pwm;

    logic        clk = 1'b0;
    logic        rst, sv, mode, clr;
    logic [15:0] smp, vol;
    logic [3:0]  mute;
    logic [1:0]  gain;
    logic [7:0]  dac;
    logic        dv, pwm, clip;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chiptune_mixer_pwm #(
        .NUM_CH(4), .SAMPLE_W(4), .VOL_W(4), .OUT_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sample_valid(sv), .i_sample_in(smp),
        .i_volume(vol), .i_mute(mute), .i_gain(gain), .i_mode(mode),
        .i_clip_clr(clr), .o_dac(dac), .o_dac_valid(dv), .o_pwm(pwm), .o_clip(clip)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int s, input int v, input logic m);
        smp[c*4 +: 4] = 4'(s);
        vol[c*4 +: 4] = 4'(v);
        mute[c]       = m;
    endtask

    task automatic strobe;
        sv = 1'b1;
        tick();
        sv = 1'b0;
    endtask

    initial begin
        int ones, first, last, bad;
        rst = 1'b1; sv = 1'b0; mode = 1'b0; clr = 1'b0; gain = 2'd0;
        smp = '0; vol = '0; mute = '0;
        tick(); tick();
        chk("rst_dac", 32'(dac), 0);
        chk("rst_dv", 32'(dv), 0);
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_clip", 32'(clip), 0);
        rst = 1'b0;

        // 1: 4 x 225 = 900, >>2 = 225, exactly 3 cycles latency
        for (int c = 0; c < 4; c++) set_ch(c, 15, 15, 1'b0);
        strobe();
        chk("t1_lat1", 32'(dv), 0);
        tick();
        chk("t1_lat2", 32'(dv), 0);
        tick();
        chk("t1_dv", 32'(dv), 1);
        chk("t1_dac", 32'(dac), 225);
        chk("t1_clip", 32'(clip), 0);
        tick();
        chk("t1_dv_pulse", 32'(dv), 0);
        chk("t1_dac_hold", 32'(dac), 225);

        // 2: gain 1 -> 450, saturates to 255, sticky clip
        gain = 2'd1;
        strobe();
        gain = 2'd0;
        tick(); tick();
        chk("t2_dac", 32'(dac), 255);
        chk("t2_clip", 32'(clip), 1);
        repeat (5) tick();
        chk("t2_clip_sticky", 32'(clip), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t2_clip_clr", 32'(clip), 0);
        gain = 2'd1;
        strobe();
        gain = 2'd0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t2_set_wins", 32'(clip), 1);
        chk("t2_dac2", 32'(dac), 255);

        // 3: ch0 only, muted voices carry nonzero data; back-to-back strobes
        set_ch(0, 1, 15, 1'b0);
        for (int c = 1; c < 4; c++) set_ch(c, 15, 15, 1'b1);
        bad = 0;
        for (int j = 0; j < 13; j++) begin
            if (j < 10) begin
                sv = 1'b1;
                smp[3:0] = 4'(j + 1);
            end else begin
                sv = 1'b0;
            end
            tick();
            if (j >= 2 && j < 12) begin
                if (dv !== 1'b1 || dac !== 8'(((j - 1) * 15) >> 2)) bad++;
            end else if (dv !== 1'b0) begin
                bad++;
            end
        end
        chk("t3_burst_errs", 32'(bad), 0);
        sv = 1'b0;
        set_ch(0, 8, 15, 1'b0);
        strobe();
        tick(); tick();
        chk("t3_dac30", 32'(dac), 30);

        // 4: PWM; two mode flips put the counter at 0 with duty 0
        mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        ones = 0;
        repeat (256) begin
            tick();
            if (pwm === 1'b1) ones++;
        end
        chk("t4_period0_ones", 32'(ones), 0);
        ones = 0; first = -1; last = -1;
        for (int k = 0; k < 256; k++) begin
            if (k == 100) begin
                set_ch(0, 15, 15, 1'b0);
                sv = 1'b1;
            end
            if (k == 101) sv = 1'b0;
            tick();
            if (pwm === 1'b1) begin
                ones++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("t4_ones30", 32'(ones), 30);
        chk("t4_first", 32'(first), 0);
        chk("t4_last", 32'(last), 29);
        chk("t4_dac56", 32'(dac), 56);
        ones = 0; first = -1; last = -1;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (pwm === 1'b1) begin
                ones++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("t4_ones56", 32'(ones), 56);
        chk("t4_first56", 32'(first), 0);
        chk("t4_last56", 32'(last), 55);

        // 5: all four voices 8*8 -> 256 >>2 = 64
        for (int c = 0; c < 4; c++) set_ch(c, 8, 8, 1'b0);
        strobe();
        tick(); tick();
        chk("t5_dac64", 32'(dac), 64);
        chk("t5_pwm_pre", 32'(pwm), 1);
        mode = 1'b1;
        #1;
        chk("t6_modechg_pwm0", 32'(pwm), 0);
        tick();
        chk("t5_sd_start", 32'(pwm), 0);
        ones = 0; bad = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (pwm === 1'b1) ones++;
            if (pwm !== ((k % 4) == 0)) bad++;
        end
        chk("t5_sd_ones64", 32'(ones), 64);
        chk("t5_sd_pattern", 32'(bad), 0);
        mute = 4'hF;
        strobe();
        tick(); tick();
        chk("t5_dac0", 32'(dac), 0);
        tick();
        ones = 0;
        repeat (256) begin
            tick();
            if (pwm !== 1'b0) ones++;
        end
        chk("t5_sd_zero", 32'(ones), 0);

        // 6: reset one cycle after a saturating strobe
        mode = 1'b0;
        tick();
        gain = 2'd1;
        for (int c = 0; c < 4; c++) set_ch(c, 15, 15, 1'b0);
        strobe();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gain = 2'd0;
        chk("t6_dac", 32'(dac), 0);
        chk("t6_clip", 32'(clip), 0);
        chk("t6_pwm", 32'(pwm), 0);
        ones = 0;
        repeat (6) begin
            tick();
            if (dv !== 1'b0) ones++;
        end
        chk("t6_no_dv", 32'(ones), 0);
        chk("t6_dac_after", 32'(dac), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
